audio_adc_rx: RTL and testbench
===============================

# audio_adc_rx

Receive-side serial audio block: deserializes the codec ADC stream (bit clock, LR clock and data all driven by the codec, which is clock master) into signed stereo sample pairs and buffers them in a small FIFO with a valid/ready stream output. It is the receive counterpart of the existing DAC serializer path on the audio_out interface. It sits between the audio_out ADC pins and the processor-side streaming logic in the system clock domain.

## Interface
- DATA_WIDTH, 16: bits per channel sample (8..32).
- FIFO_DEPTH, 8: stereo pairs buffered; power of two, 2..64.
- clk  input  1  system clock, 50 MHz (clk_50_clk domain).
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = capture; 0 = stop pushing and return to alignment.
- adc_bclk  input  1  codec bit clock, asynchronous to clk.
- adc_lrck  input  1  codec LR clock, asynchronous; 0 = left, 1 = right.
- adc_dat  input  1  codec serial data, MSB first.
- out_data  output  2*DATA_WIDTH  {left, right}, left in the upper half.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data when out_valid is 1.
- fill_level  output  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- overflow  output  1  sticky: a pair was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow.

## Operation
- Inputs adc_bclk, adc_lrck and adc_dat each pass through a 2-flop synchronizer. A rising edge of synchronized bclk is the bit strobe; lrck and dat are sampled only on the strobe.
- Format is I2S: the MSB arrives on the second BCLK rising edge after an LRCK transition. The first strobe after a transition is a delay slot.
- FSM states:
  - ALIGN: reset state, and entered whenever enable=0. Moves to LEFT on the first strobe where lrck changes 1->0.
  - LEFT: shift bits into the left register. Moves to RIGHT on an lrck 0->1 change.
  - RIGHT: shift bits into the right register. On an lrck 1->0 change, push {left, right} and go to LEFT.
- Each channel shifts in DATA_WIDTH bits. Bits beyond DATA_WIDTH are ignored. A short word is left-aligned with its LSBs zero-filled. The per-channel bit counter saturates at DATA_WIDTH.
- A push while the FIFO is full is dropped and sets overflow. If push and pop happen in the same cycle with the FIFO full, both succeed and overflow is not set.
- ovf_clr clears overflow. If ovf_clr coincides with an overflow event, the set wins.
- Deasserting enable discards the partial pair. FIFO contents stay readable.

## Timing
- Reset values: out_valid=0, fill_level=0, overflow=0, out_data=0. FSM=ALIGN, shift registers and bit counters 0, FIFO pointers 0.
- Pin-to-strobe latency is 3 clk: 2 synchronizer flops plus 1 edge-detect flop.
- The push occurs on the clk cycle after the strobe that detects lrck 1->0. out_valid rises 1 clk after the push into an empty FIFO.
- Transfer occurs on a clk edge with out_valid & out_ready. out_data shows the head entry combinationally from the registered FIFO memory (first-word fall-through).
- The BCLK high and low phases must each last at least 3 clk. With 50 MHz this supports BCLK up to 8 MHz, covering 48 kHz x 64 BCLK = 3.072 MHz.
- Reset asserted mid-frame takes effect on the next clk edge and overrides all other inputs.

## Configuration
- AUDIO_ADC_RX_OVF_CNT_EN defined:
  - Adds output ovf_count (16 bits), which counts dropped pairs.
  - The counter saturates at 0xFFFF and is cleared by ovf_clr.
  - If ovf_clr and a drop occur in the same cycle, ovf_count becomes 1.
- Macro not defined: the ovf_count port and its logic are absent. Only the sticky overflow flag exists.

## Structure
- Package audio_pkg holds:
  - the FSM state enum, rx_state_t with values ALIGN, LEFT, RIGHT;
  - localparam SYNC_STAGES = 2;
  - the stereo pair struct typedef, with left and right fields of logic signed [DATA_WIDTH-1:0], parameterized through the module.
- Sub-module audio_rx_fifo is a synchronous FIFO (FIFO_DEPTH x 2*DATA_WIDTH). It provides first-word fall-through, push/pop/full/empty/level, and is reusable by the DAC path.
- Top level holds the synchronizers, edge detect, FSM, shift registers and overflow logic.

## Test plan
- Nominal frame:
  - Stimulus: BCLK = 16 clk period, 32 BCLK per channel, enable=1. Send left = 0x8001 and right = 0x7FFE after one alignment frame.
  - Required: fill_level reaches 1 and out_data = 0x80017FFE. The first partial frame after reset produces no push.
- Short word:
  - Stimulus: DATA_WIDTH=16, 12 bits per channel, left 0xABC, right 0x123.
  - Required: out_data = 0xABC01230.
- Overflow and clear:
  - Stimulus: FIFO_DEPTH=8, out_ready=0, send 9 frames.
  - Required: fill_level=8 and overflow=1. With the macro, ovf_count=1. After one ovf_clr pulse, overflow=0 and ovf_count=0.
- Full, push and pop in the same cycle:
  - Stimulus: FIFO full, out_ready=1 on the exact push cycle.
  - Required: fill_level stays 8, overflow stays 0, output order preserved.
- Enable drop mid-word:
  - Stimulus: enable deasserted halfway through a left word, reasserted 2 frames later.
  - Required: no partial pair is pushed, and the next pair is pushed only after a new lrck 1->0 alignment.
- Reset mid-frame:
  - Stimulus: reset pulsed for 1 clk with 3 pairs queued.
  - Required: fill_level=0, out_valid=0 and overflow=0 on the next cycle, then re-alignment before any push.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the serial audio receive path.
//   rx_state_t     - frame alignment FSM state (ALIGN, LEFT, RIGHT)
//   SYNC_STAGES    - depth of the pin synchronizers (must be >= 2)
//   MAX_DATA_WIDTH - widest supported channel sample
//   stereo_max_t   - stereo pair at the maximum width. The active design
//                    declares a pair type sized by its own DATA_WIDTH with the
//                    same field layout (left in the upper half).
package audio_pkg;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int MAX_DATA_WIDTH = 32;

    typedef struct packed {
        logic signed [MAX_DATA_WIDTH-1:0] left;
        logic signed [MAX_DATA_WIDTH-1:0] right;
    } stereo_max_t;

endpackage

// File: rtl/audio_rx_fifo.sv
// audio_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset        - clock, synchronous active-high reset
//   push, push_data   - write request and data (ignored when full unless popping)
//   pop               - read request (ignored when empty)
//   pop_data          - head entry, combinational from the memory; 0 when empty
//   full, empty       - status
//   level             - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module audio_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
    logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
    logic [LW-1:0]    count_d, count_q;
    logic             wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));

    // When full, a simultaneous pop frees the head slot on the same edge,
    // so the write into that slot is safe.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S receiver for the codec ADC stream (codec is clock master).
// Synchronizes bclk/lrck/dat into clk, deserializes left/right words and
// queues {left, right} pairs in a FWFT FIFO with a valid/ready output.
//   clk, reset            - system clock, synchronous active-high reset
//   enable                - 1 = capture, 0 = drop partial pair and realign
//   adc_bclk/lrck/dat     - asynchronous codec pins (lrck 0 = left)
//   out_data/valid/ready  - stream output, {left, right}, left in upper half
//   fill_level            - pairs stored
//   overflow, ovf_clr     - sticky drop flag and its clear (set wins)
//   ovf_count             - saturating drop counter, only present when
//                           AUDIO_ADC_RX_OVF_CNT_EN is defined
//
// state | meaning
// ALIGN | waiting for an lrck 1->0 change to find the start of a left word
// LEFT  | shifting bits into the left word
// RIGHT | shifting bits into the right word; lrck 1->0 pushes the pair
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            adc_bclk,
    input  logic                            adc_lrck,
    input  logic                            adc_dat,
    output logic [2*DATA_WIDTH-1:0]         out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fill_level,
    output logic                            overflow,
    input  logic                            ovf_clr
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    ,
    output logic [15:0]                     ovf_count
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] left;
        logic signed [DATA_WIDTH-1:0] right;
    } pair_t;

    logic [SYNC_STAGES-1:0] bclk_sync_d, bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_d, lrck_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_d,  dat_sync_q;
    logic                   bclk_s, lrck_s, dat_s;

    logic bclk_prev_d, bclk_prev_q;
    logic strobe_d, strobe_q;
    logic lrck_smp_d, lrck_smp_q;
    logic dat_smp_d, dat_smp_q;
    logic lrck_last_d, lrck_last_q;
    logic lrck_fall, lrck_rise;

    rx_state_t              state_d, state_q;
    logic [DATA_WIDTH-1:0]  left_d, left_q;
    logic [DATA_WIDTH-1:0]  right_d, right_q;
    logic [CW-1:0]          left_cnt_d, left_cnt_q;
    logic [CW-1:0]          right_cnt_d, right_cnt_q;
    logic                   push_d, push_q;
    pair_t                  pair_d, pair_q;

    logic fifo_full, fifo_empty, pop, drop;
    logic overflow_d, overflow_q;

    // Synchronizers, then a registered rising-edge strobe. lrck/dat are
    // registered alongside the strobe so all three line up.
    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign dat_s  = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], adc_bclk};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], adc_lrck};
        dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], adc_dat};
        bclk_prev_d = bclk_s;
        strobe_d    = bclk_s & ~bclk_prev_q;
        lrck_smp_d  = lrck_s;
        dat_smp_d   = dat_s;
        lrck_last_d = strobe_q ? lrck_smp_q : lrck_last_q;
    end

    assign lrck_fall = strobe_q &  lrck_last_q & ~lrck_smp_q;
    assign lrck_rise = strobe_q & ~lrck_last_q &  lrck_smp_q;

    // The strobe that sees an lrck change is the I2S delay slot and carries
    // no bit of the new word, so transitions never shift. Bits land at the
    // position selected by the counter, which left-aligns short words.
    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        left_cnt_d  = left_cnt_q;
        right_cnt_d = right_cnt_q;
        push_d      = 1'b0;
        pair_d      = pair_q;

        if (!enable) begin
            state_d     = ALIGN;
            left_d      = '0;
            right_d     = '0;
            left_cnt_d  = '0;
            right_cnt_d = '0;
        end else if (strobe_q) begin
            case (state_q)
                ALIGN: begin
                    if (lrck_fall) begin
                        state_d    = LEFT;
                        left_d     = '0;
                        left_cnt_d = '0;
                    end
                end
                LEFT: begin
                    if (lrck_rise) begin
                        state_d     = RIGHT;
                        right_d     = '0;
                        right_cnt_d = '0;
                    end else if (left_cnt_q < CW'(DATA_WIDTH)) begin
                        left_d     = left_q | ({DATA_WIDTH{dat_smp_q}} & (MSB_ONE >> left_cnt_q));
                        left_cnt_d = left_cnt_q + CW'(1);
                    end
                end
                RIGHT: begin
                    if (lrck_fall) begin
                        push_d      = 1'b1;
                        pair_d.left  = left_q;
                        pair_d.right = right_q;
                        state_d     = LEFT;
                        left_d      = '0;
                        left_cnt_d  = '0;
                    end else if (right_cnt_q < CW'(DATA_WIDTH)) begin
                        right_d     = right_q | ({DATA_WIDTH{dat_smp_q}} & (MSB_ONE >> right_cnt_q));
                        right_cnt_d = right_cnt_q + CW'(1);
                    end
                end
                default: state_d = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            strobe_q    <= 1'b0;
            lrck_smp_q  <= 1'b0;
            dat_smp_q   <= 1'b0;
            lrck_last_q <= 1'b0;
            state_q     <= ALIGN;
            left_q      <= '0;
            right_q     <= '0;
            left_cnt_q  <= '0;
            right_cnt_q <= '0;
            push_q      <= 1'b0;
            pair_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            dat_sync_q  <= dat_sync_d;
            bclk_prev_q <= bclk_prev_d;
            strobe_q    <= strobe_d;
            lrck_smp_q  <= lrck_smp_d;
            dat_smp_q   <= dat_smp_d;
            lrck_last_q <= lrck_last_d;
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            left_cnt_q  <= left_cnt_d;
            right_cnt_q <= right_cnt_d;
            push_q      <= push_d;
            pair_q      <= pair_d;
            overflow_q  <= overflow_d;
        end
    end

    audio_rx_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (pair_q),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fill_level)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // A pop on the push cycle makes room, so only an unpaired push into a
    // full FIFO is a drop.
    assign drop       = push_q & fifo_full & ~pop;
    assign overflow_d = drop | (overflow_q & ~ovf_clr);
    assign overflow   = overflow_q;

`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt_d, ovf_cnt_q;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop) begin
            if (ovf_clr)
                ovf_cnt_d = 16'd1;
            else if (ovf_cnt_q != 16'hFFFF)
                ovf_cnt_d = ovf_cnt_q + 16'd1;
        end else if (ovf_clr) begin
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
module tb_audio_adc_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        adc_bclk = 1'b0;
    logic        adc_lrck = 1'b0;
    logic        adc_dat = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  fill_level;
    logic        overflow;
    logic        ovf_clr = 1'b0;
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    audio_adc_rx #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .adc_bclk   (adc_bclk),
        .adc_lrck   (adc_lrck),
        .adc_dat    (adc_dat),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    // One channel half-frame of 32 BCLK slots (16 clk each). Slot 0 is the
    // I2S delay slot; slots 1..nbits carry data MSB first, the rest are 0.
    // With pop_hook, out_ready is high across exactly the clk edge on which
    // the slot-0 push lands (bclk rise + 2 sync + strobe + push register).
    task automatic drive_half(input logic lr, input logic [31:0] data, input int nbits,
                              input int first_slot, input int last_slot,
                              input bit pop_hook, output logic [31:0] popped);
        logic [31:0] tmp;
        popped = '0;
        for (int s = first_slot; s <= last_slot; s++) begin
            @(negedge clk);
            adc_bclk = 1'b0;
            adc_lrck = lr;
            tmp = (s >= 1 && s <= nbits) ? (data >> (nbits - s)) : 32'd0;
            adc_dat = tmp[0];
            repeat (8) @(negedge clk);
            adc_bclk = 1'b1;
            if (pop_hook && s == 0) begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
                popped = out_data;
                @(negedge clk);
                out_ready = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (7) @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        logic [31:0] dummy;
        drive_half(1'b0, l, nbits, 0, 31, 1'b0, dummy);
        drive_half(1'b1, r, nbits, 0, 31, 1'b0, dummy);
    endtask

    task automatic flush_left();
        logic [31:0] dummy;
        drive_half(1'b0, 32'd0, 16, 0, 31, 1'b0, dummy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        adc_bclk = 1'b0;
        adc_lrck = 1'b0;
        adc_dat = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
`endif
    endtask

    task automatic test_nominal();
        send_frame(32'hFFFF, 32'hFFFF, 16);
        send_frame(32'h8001, 32'h7FFE, 16);
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL nominal_no_early_push got %0d want 0", fill_level); end
        flush_left();
        checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL nominal_fill got %0d want 1", fill_level); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nominal_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h80017FFE) begin errors++; $display("FAIL nominal_data got %h want 80017ffe", out_data); end
        pop_one();
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL nominal_pop_fill got %0d want 0", fill_level); end
    endtask

    task automatic test_short_word();
        do_reset();
        send_frame(32'hFFFF, 32'hFFFF, 16);
        send_frame(32'hABC, 32'h123, 12);
        flush_left();
        checks++; if (out_data !== 32'hABC01230) begin errors++; $display("FAIL short_word got %h want abc01230", out_data); end
    endtask

    // Leaves the FIFO full with pairs 1..8 and the left half of pair 10 sent.
    task automatic test_overflow();
        logic [31:0] dummy;
        do_reset();
        send_frame(32'hFFFF, 32'hFFFF, 16);
        for (int i = 1; i <= 9; i++)
            send_frame(32'h1000 + i, 32'h2000 + i, 16);
        drive_half(1'b0, 32'h100A, 16, 0, 31, 1'b0, dummy);
        checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL ovf_fill got %0d want 8", fill_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        checks++; if (ovf_count !== 16'd1) begin errors++; $display("FAIL ovf_count got %0d want 1", ovf_count); end
`endif
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL ovf_count_clear got %0d want 0", ovf_count); end
`endif
    endtask

    task automatic test_full_push_pop();
        logic [31:0] dummy, popped, exp;
        drive_half(1'b1, 32'h200A, 16, 0, 31, 1'b0, dummy);
        drive_half(1'b0, 32'h100B, 16, 0, 31, 1'b1, popped);
        checks++; if (popped !== 32'h10012001) begin errors++; $display("FAIL fullpp_popped got %h want 10012001", popped); end
        checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL fullpp_fill got %0d want 8", fill_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %0b want 0", overflow); end
        for (int k = 0; k < 8; k++) begin
            exp = (k < 7) ? {16'h1000 + 16'(k + 2), 16'h2000 + 16'(k + 2)} : 32'h100A200A;
            @(negedge clk);
            checks++; if (out_data !== exp) begin errors++; $display("FAIL fullpp_order%0d got %h want %h", k, out_data, exp); end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL fullpp_drained got %0d want 0", fill_level); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] dummy;
        do_reset();
        send_frame(32'hFFFF, 32'hFFFF, 16);
        send_frame(32'h1111, 32'h2222, 16);
        drive_half(1'b0, 32'h3333, 16, 0, 7, 1'b0, dummy);
        enable = 1'b0;
        drive_half(1'b0, 32'h3333, 16, 8, 31, 1'b0, dummy);
        drive_half(1'b1, 32'h4444, 16, 0, 31, 1'b0, dummy);
        send_frame(32'h5555, 32'h6666, 16);
        drive_half(1'b0, 32'h9999, 16, 0, 7, 1'b0, dummy);
        enable = 1'b1;
        drive_half(1'b0, 32'h9999, 16, 8, 31, 1'b0, dummy);
        drive_half(1'b1, 32'hAAAA, 16, 0, 31, 1'b0, dummy);
        checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL en_drop_partial got %0d want 1", fill_level); end
        send_frame(32'h7777, 32'h8888, 16);
        checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL en_realign got %0d want 1", fill_level); end
        flush_left();
        checks++; if (fill_level !== 4'd2) begin errors++; $display("FAIL en_after got %0d want 2", fill_level); end
        checks++; if (out_data !== 32'h11112222) begin errors++; $display("FAIL en_first got %h want 11112222", out_data); end
        pop_one();
        checks++; if (out_data !== 32'h77778888) begin errors++; $display("FAIL en_second got %h want 77778888", out_data); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dummy;
        do_reset();
        send_frame(32'hFFFF, 32'hFFFF, 16);
        for (int i = 1; i <= 3; i++)
            send_frame(32'hA000 + i, 32'hB000 + i, 16);
        drive_half(1'b0, 32'hDEAD, 16, 0, 9, 1'b0, dummy);
        checks++; if (fill_level !== 4'd3) begin errors++; $display("FAIL rstmid_pre got %0d want 3", fill_level); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL rstmid_fill got %0d want 0", fill_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %0b want 0", overflow); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rstmid_data got %h want 0", out_data); end
        drive_half(1'b0, 32'hDEAD, 16, 10, 31, 1'b0, dummy);
        drive_half(1'b1, 32'hBEEF, 16, 0, 31, 1'b0, dummy);
        send_frame(32'h0F0F, 32'hF0F0, 16);
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL rstmid_realign got %0d want 0", fill_level); end
        flush_left();
        checks++; if (fill_level !== 4'd1) begin errors++; $display("FAIL rstmid_push got %0d want 1", fill_level); end
        checks++; if (out_data !== 32'h0F0FF0F0) begin errors++; $display("FAIL rstmid_out got %h want 0f0ff0f0", out_data); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_word();
        test_overflow();
        test_full_push_pop();
        test_enable_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
